// File: rtl/square_period_detector.sv
// Period recovery for square-like audio: a hysteresis comparator qualifies rising edges,
// a tick counter times them, and contiguous windows of 2^AVG_LOG2 periods are averaged.
module square_period_detector #(
    parameter int                  SAMPLE_W   = 8,
    parameter int                  HYST       = 4,
    parameter int                  PERIOD_W   = 16,
    parameter int                  AVG_LOG2   = 2,
    parameter logic [PERIOD_W-1:0] MAX_PERIOD = 16'hFFFF
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                step_in,
    input  logic [SAMPLE_W-1:0] sample_in,
    output logic [PERIOD_W-1:0] period_out,
    output logic                period_valid_out,
    output logic                locked_out,
    output logic                timeout_out
);

    localparam int ACC_W = PERIOD_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0]           LAST_IDX = CNT_W'((2 ** AVG_LOG2) - 1);
    localparam logic [CNT_W-1:0]           CNT_ONE  = CNT_W'(1'b1);
    localparam logic [PERIOD_W-1:0]        TICK_ONE = PERIOD_W'(1'b1);
    localparam logic signed [SAMPLE_W-1:0] HYST_POS = SAMPLE_W'(HYST);
    localparam logic signed [SAMPLE_W-1:0] HYST_NEG = -HYST_POS;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    function automatic logic [PERIOD_W-1:0] window_avg(input logic [ACC_W-1:0] sum);
        logic [ACC_W-1:0] shifted;
        shifted = sum >> AVG_LOG2;
        return shifted[PERIOD_W-1:0];
    endfunction

    state_t              state_r, state_s;
    logic                level_r, level_s;
    logic [PERIOD_W-1:0] counter_r, counter_s;
    logic [ACC_W-1:0]    acc_r, acc_s;
    logic [CNT_W-1:0]    count_r, count_s;
    logic [PERIOD_W-1:0] period_r, period_s;
    logic                valid_r, valid_s;
    logic                locked_r, locked_s;
    logic                timeout_r, timeout_s;

    logic signed [SAMPLE_W-1:0] sample_s;
    logic                       hi_s;
    logic                       lo_s;
    logic                       rising_s;
    logic [ACC_W-1:0]           sum_s;

    // Next-state and output logic; nothing but the pulses changes without a tick
    always_comb begin
        state_s   = state_r;
        level_s   = level_r;
        counter_s = counter_r;
        acc_s     = acc_r;
        count_s   = count_r;
        period_s  = period_r;
        locked_s  = locked_r;
        valid_s   = 1'b0;
        timeout_s = 1'b0;

        sample_s = $signed(sample_in);
        hi_s     = (sample_s >= HYST_POS);
        lo_s     = (sample_s <= HYST_NEG);
        rising_s = step_in && !level_r && hi_s;
        // counter_r holds the tick distance to the previous edge, i.e. the period P
        sum_s    = acc_r + ACC_W'(counter_r);

        if (step_in) begin
            if (hi_s) begin
                level_s = 1'b1;
            end else if (lo_s) begin
                level_s = 1'b0;
            end else begin
                level_s = level_r;
            end

            case (state_r)
                IDLE: begin
                    if (rising_s) begin
                        state_s   = MEASURE;
                        counter_s = TICK_ONE;
                        acc_s     = {ACC_W{1'b0}};
                        count_s   = {CNT_W{1'b0}};
                    end else begin
                        state_s = IDLE;
                    end
                end
                MEASURE: begin
                    if (rising_s) begin
                        counter_s = TICK_ONE;
                        if (count_r == LAST_IDX) begin
                            period_s = window_avg(sum_s);
                            valid_s  = 1'b1;
                            locked_s = 1'b1;
                            acc_s    = {ACC_W{1'b0}};
                            count_s  = {CNT_W{1'b0}};
                        end else begin
                            acc_s   = sum_s;
                            count_s = count_r + CNT_ONE;
                        end
                    end else if (counter_r >= MAX_PERIOD) begin
                        timeout_s = 1'b1;
                        locked_s  = 1'b0;
                        period_s  = {PERIOD_W{1'b0}};
                        state_s   = IDLE;
                        counter_s = {PERIOD_W{1'b0}};
                        acc_s     = {ACC_W{1'b0}};
                        count_s   = {CNT_W{1'b0}};
                    end else begin
                        counter_s = counter_r + TICK_ONE;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end else begin
            level_s = level_r;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r   <= IDLE;
            level_r   <= 1'b0;
            counter_r <= {PERIOD_W{1'b0}};
            acc_r     <= {ACC_W{1'b0}};
            count_r   <= {CNT_W{1'b0}};
            period_r  <= {PERIOD_W{1'b0}};
            valid_r   <= 1'b0;
            locked_r  <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            level_r   <= level_s;
            counter_r <= counter_s;
            acc_r     <= acc_s;
            count_r   <= count_s;
            period_r  <= period_s;
            valid_r   <= valid_s;
            locked_r  <= locked_s;
            timeout_r <= timeout_s;
        end
    end

    assign period_out       = period_r;
    assign period_valid_out = valid_r;
    assign locked_out       = locked_r;
    assign timeout_out      = timeout_r;

endmodule

// File: doc/square_period_detector.md
Name: square_period_detector

Overview:
- Receive side of the tone path: consumes signed 8-bit audio samples at the step rate and recovers the fundamental period of a square-like waveform, in step ticks.
- Rising zero crossings are qualified by a hysteresis comparator and timed with a tick counter.
- Periods are averaged over fixed windows.
- Used to close the loop on the square generator: loopback checks, and pitch readback for display and calibration.

Parameters:
- SAMPLE_W, 8, sample width (two's complement).
- HYST, 4, hysteresis threshold magnitude; must satisfy 0 < HYST < 2^(SAMPLE_W-1).
- PERIOD_W, 16, width of period counter and period_out.
- AVG_LOG2, 2, log2 of the number of periods averaged per window.
- MAX_PERIOD, 16'hFFFF, tick count at which the timeout fires; must satisfy 2 <= MAX_PERIOD <= 2^PERIOD_W-1.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-high.
- step_in  input  1  sample strobe; one tick per asserted cycle.
- sample_in  input  SAMPLE_W  signed sample; valid when step_in=1.
- period_out  output  PERIOD_W  averaged period in ticks; holds between updates.
- period_valid_out  output  1  one-cycle pulse when period_out updates.
- locked_out  output  1  high after the first completed window, until a timeout or reset.
- timeout_out  output  1  one-cycle pulse when the timeout fires.

Behaviour:
- Clock and reset: one clock, clk_in. rst_in is asynchronous, active-high. While it is asserted, all state is cleared immediately:
  - level=LOW, state=IDLE;
  - counter=0, accumulator=0, period count=0;
  - period_out=0, period_valid_out=0, locked_out=0, timeout_out=0.
- Gating: all state advances only in cycles with step_in=1. With step_in=0, registers hold and both pulse outputs are 0.
- Comparator:
  - On a tick, if sample_in >= +HYST (signed compare), level becomes HIGH.
  - If sample_in <= -HYST, level becomes LOW.
  - Otherwise level holds.
  - A rising event is a tick where level goes LOW->HIGH. Because level resets to LOW, the first qualifying high sample after reset counts as a rising event.
- Counter: on a rising-event tick the counter is loaded with 1; on every other tick it increments, saturating at MAX_PERIOD. The measured period P is the counter value on the tick immediately before a rising event, so edges at ticks n and n+P give P.
- FSM state IDLE:
  - counter is inactive.
  - A rising event moves the FSM to MEASURE and clears the accumulator and period count. No period is recorded for this edge.
- FSM state MEASURE:
  - Each rising event adds P to the accumulator (width PERIOD_W+AVG_LOG2, no overflow possible) and increments the period count.
  - When the count reaches 2^AVG_LOG2, on the following clock edge:
    - period_out = accumulator >> AVG_LOG2 (truncating);
    - period_valid_out pulses for one cycle;
    - locked_out is set;
    - accumulator and count clear.
  - The edge that closes a window also opens the next one; windows are contiguous and non-overlapping.
  - Latency: the pulse is registered in the cycle after the closing step_in cycle.
- Timeout:
  - Fires on a tick in MEASURE where the counter would reach MAX_PERIOD with no rising event.
  - Next clock edge: timeout_out pulses, locked_out=0, period_out=0, FSM goes to IDLE, accumulator clears.
  - A rising event on the same tick that the counter hits MAX_PERIOD takes priority: the period is recorded as MAX_PERIOD and no timeout occurs.
- Simultaneity: period_valid_out and timeout_out are never asserted in the same cycle.
- Minimum measurable period is 2 ticks; a level change requires crossing the hysteresis band, so a sample pattern with a 1-tick period cannot occur.

Test Plan:
- Generator-style stream of +7,+7,-8,-8 repeating (period 4), HYST=4, AVG_LOG2=2 -> arming edge at tick 0 and edges every 4 ticks. First period_valid_out one cycle after tick 16 with period_out=4, locked_out=1, then a pulse every 16 ticks.
- Period-10 square (+7 x5, -8 x5) with ±3 noise injected on every sample -> no extra rising events; period_out=10.
- Edge spacing 5,5,6,6 -> sum 22, period_out=5 (truncation); next window of 6,6,6,6 -> period_out=6.
- MAX_PERIOD=64, locked, then constant +7 -> timeout_out pulses once, 64 ticks after the last edge. locked_out=0 and period_out=0 on the same clock edge; the next edge re-arms from IDLE with no spurious valid pulse.
- Period-4 stream with step_in held low for 100 cycles mid-window and sample_in randomised during the gap -> the window result is still exactly 4, and no pulses appear during the gap.
- Assert rst_in asynchronously (between clk_in edges) mid-window -> all outputs are 0 before the next clock edge. After release, behaviour matches the first scenario from tick 0.
